// File: rtl/lfsr_cipher_ctrl_if.sv
// Byte-stream handshake between the LFSR cipher controller and its
// producer/consumer: plaintext in, XOR-ed result out.
interface lfsr_cipher_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  // master: the environment that feeds bytes and drains results
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lfsr_cipher_ctrl.sv
// Stream-cipher controller: keys an external Galois LFSR, discards a warm-up
// run, then XORs each accepted byte with 8 keystream bits taken MSB first.
module lfsr_cipher_ctrl #(
  parameter int N      = 32,
  parameter int WARMUP = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [N-1:0]      cfg_seed,
  input  logic [N-1:0]      cfg_taps,
  lfsr_cipher_ctrl_if.slave bus,
  output logic              busy,
  output logic              lfsr_ld,
  output logic              lfsr_en,
  output logic [N-1:0]      lfsr_seed,
  output logic [N-1:0]      lfsr_taps,
  input  logic              lfsr_k
);

  localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WCNT_W-1:0] WARM_LAST = (WARMUP > 0) ? WCNT_W'(WARMUP - 1) : '0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WARM = 3'd2,
    RUN  = 3'd3,
    GEN  = 3'd4,
    HOLD = 3'd5
  } state_t;

  state_t            state_reg,    state_next;
  logic [WCNT_W-1:0] warm_cnt_reg, warm_cnt_next;
  logic [3:0]        bit_cnt_reg,  bit_cnt_next;
  logic [7:0]        key_reg,      key_next;
  logic [7:0]        data_reg,     data_next;
  logic [7:0]        out_data_reg, out_data_next;
  logic [N-1:0]      seed_reg,     seed_next;
  logic [N-1:0]      taps_reg,     taps_next;
  logic              rekey;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      warm_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      key_reg      <= '0;
      data_reg     <= '0;
      out_data_reg <= '0;
      seed_reg     <= '0;
      taps_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      warm_cnt_reg <= warm_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      key_reg      <= key_next;
      data_reg     <= data_next;
      out_data_reg <= out_data_next;
      seed_reg     <= seed_next;
      taps_reg     <= taps_next;
    end
  end

  // Rekey is only honoured when no keystream is in flight; it beats a byte in RUN.
  assign rekey = cfg_start && ((state_reg == IDLE) || (state_reg == RUN));

  always_comb begin
    state_next    = state_reg;
    warm_cnt_next = warm_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    key_next      = key_reg;
    data_next     = data_reg;
    out_data_next = out_data_reg;
    seed_next     = seed_reg;
    taps_next     = taps_reg;

    if (rekey) begin
      // An all-zero seed would lock the LFSR at zero forever.
      seed_next  = (cfg_seed == '0) ? '1 : cfg_seed;
      taps_next  = cfg_taps;
      state_next = LOAD;
    end else begin
      case (state_reg)
        IDLE: state_next = IDLE;
        LOAD: begin
          warm_cnt_next = WARM_LAST;
          state_next    = (WARMUP == 0) ? RUN : WARM;
        end
        WARM: begin
          if (warm_cnt_reg == '0) begin
            state_next = RUN;
          end else begin
            warm_cnt_next = warm_cnt_reg - 1'b1;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            data_next    = bus.in_data;
            key_next     = '0;
            bit_cnt_next = '0;
            state_next   = GEN;
          end
        end
        GEN: begin
          // Cycles 0..7 collect key bits; cycle 8 has a complete key to apply.
          if (bit_cnt_reg[3]) begin
            out_data_next = data_reg ^ key_reg;
            state_next    = HOLD;
          end else begin
            key_next[3'd7 - bit_cnt_reg[2:0]] = lfsr_k;
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Strobes come straight from registered state so no input reaches the LFSR.
  assign lfsr_ld       = (state_reg == LOAD);
  assign lfsr_en       = (state_reg == WARM) || ((state_reg == GEN) && !bit_cnt_reg[3]);
  assign busy          = (state_reg != IDLE) && (state_reg != RUN);
  assign bus.in_ready  = (state_reg == RUN);
  assign bus.out_valid = (state_reg == HOLD);
  assign bus.out_data  = out_data_reg;
  assign lfsr_seed     = seed_reg;
  assign lfsr_taps     = taps_reg;

endmodule

// File: tb/tb_lfsr_cipher_ctrl.sv
// Bench for lfsr_cipher_ctrl: two instances (WARMUP=0 and default) each drive
// a behavioural Galois LFSR; results are compared with a keystream model.
module tb_lfsr_cipher_ctrl;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         cfg_start [2];
  logic [N-1:0] cfg_seed  [2];
  logic [N-1:0] cfg_taps  [2];
  logic         in_valid  [2];
  logic [7:0]   in_data   [2];
  logic         out_ready [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic [7:0]   out_data  [2];
  logic         busy      [2];
  logic         lfsr_ld   [2];
  logic         lfsr_en   [2];
  logic [N-1:0] lfsr_seed [2];
  logic [N-1:0] lfsr_taps [2];
  logic         lfsr_k    [2];

  // Reference keystream state per instance, advanced only from spec-level rules.
  logic [N-1:0] ref_st   [2];
  logic [N-1:0] ref_taps [2];

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s, input logic [N-1:0] t);
    return (s << 1) ^ (s[N-1] ? t : '0);
  endfunction

  function automatic int warm_of(input int u);
    return (u == 0) ? 0 : 64;
  endfunction

  lfsr_cipher_ctrl_if ia ();
  lfsr_cipher_ctrl_if ib ();

  assign ia.in_valid  = in_valid[0];
  assign ia.in_data   = in_data[0];
  assign ia.out_ready = out_ready[0];
  assign in_ready[0]  = ia.in_ready;
  assign out_valid[0] = ia.out_valid;
  assign out_data[0]  = ia.out_data;

  assign ib.in_valid  = in_valid[1];
  assign ib.in_data   = in_data[1];
  assign ib.out_ready = out_ready[1];
  assign in_ready[1]  = ib.in_ready;
  assign out_valid[1] = ib.out_valid;
  assign out_data[1]  = ib.out_data;

  lfsr_cipher_ctrl #(.N(N), .WARMUP(0)) dut0 (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start[0]), .cfg_seed(cfg_seed[0]), .cfg_taps(cfg_taps[0]),
    .bus(ia),
    .busy(busy[0]), .lfsr_ld(lfsr_ld[0]), .lfsr_en(lfsr_en[0]),
    .lfsr_seed(lfsr_seed[0]), .lfsr_taps(lfsr_taps[0]), .lfsr_k(lfsr_k[0])
  );

  lfsr_cipher_ctrl #(.N(N)) dut1 (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start[1]), .cfg_seed(cfg_seed[1]), .cfg_taps(cfg_taps[1]),
    .bus(ib),
    .busy(busy[1]), .lfsr_ld(lfsr_ld[1]), .lfsr_en(lfsr_en[1]),
    .lfsr_seed(lfsr_seed[1]), .lfsr_taps(lfsr_taps[1]), .lfsr_k(lfsr_k[1])
  );

  // External Galois LFSR driven by each controller's strobes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lfsr
    logic [N-1:0] st;
    always @(posedge clk or posedge rst) begin
      if (rst)              st <= '0;
      else if (lfsr_ld[gi]) st <= lfsr_seed[gi];
      else if (lfsr_en[gi]) st <= lfsr_step(st, lfsr_taps[gi]);
    end
    assign lfsr_k[gi] = st[N-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rekey(input int u, input logic [N-1:0] seed, input logic [N-1:0] taps,
                       input bit with_byte);
    int en_cnt;
    int cyc;
    int ld_extra;
    logic [N-1:0] eff;
    eff = (seed == '0) ? '1 : seed;
    cfg_start[u] = 1'b1;
    cfg_seed[u]  = seed;
    cfg_taps[u]  = taps;
    if (with_byte) begin
      in_valid[u] = 1'b1;
      in_data[u]  = 8'hC3;
    end
    tick();
    cfg_start[u] = 1'b0;
    in_valid[u]  = 1'b0;
    cfg_seed[u]  = $urandom;
    cfg_taps[u]  = $urandom;
    check("load_ld", lfsr_ld[u], 1);
    check("load_en", lfsr_en[u], 0);
    check("load_in_ready", in_ready[u], 0);
    check("load_busy", busy[u], 1);
    check("lfsr_seed", lfsr_seed[u], eff);
    check("lfsr_taps", lfsr_taps[u], taps);
    en_cnt = 0;
    cyc = 0;
    ld_extra = 0;
    tick();
    while (!in_ready[u] && cyc < 200) begin
      if (lfsr_en[u]) en_cnt++;
      if (lfsr_ld[u]) ld_extra++;
      cyc++;
      tick();
    end
    check("warm_en_cycles", en_cnt, warm_of(u));
    check("warm_len", cyc, warm_of(u));
    check("ld_once", ld_extra, 0);
    check("run_ready", in_ready[u], 1);
    check("run_busy", busy[u], 0);
    ref_st[u]   = eff;
    ref_taps[u] = taps;
    for (int i = 0; i < warm_of(u); i++) ref_st[u] = lfsr_step(ref_st[u], taps);
    $display("rekey u=%0d seed=%08h taps=%08h byte_too=%0d warm_en=%0d", u, seed, taps,
             with_byte, en_cnt);
  endtask

  task automatic send(input int u, input logic [7:0] b, input int hold, output logic [7:0] got);
    int n;
    int en_cnt;
    int rdy_seen;
    logic [7:0] key;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      key = {key[6:0], ref_st[u][N-1]};
      ref_st[u] = lfsr_step(ref_st[u], ref_taps[u]);
    end
    check("accept_ready", in_ready[u], 1);
    in_valid[u]  = 1'b1;
    in_data[u]   = b;
    out_ready[u] = 1'b0;
    tick();
    in_valid[u] = 1'b0;
    in_data[u]  = 8'($urandom);
    n = 0;
    en_cnt = 0;
    rdy_seen = 0;
    while (!out_valid[u] && n < 30) begin
      if (lfsr_en[u]) en_cnt++;
      if (in_ready[u]) rdy_seen++;
      n++;
      tick();
    end
    check("latency", n, 9);
    check("gen_en_cycles", en_cnt, 8);
    check("gen_in_ready", rdy_seen, 0);
    check("out_data", out_data[u], b ^ key);
    got = out_data[u];
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", out_valid[u], 1);
      check("hold_data", out_data[u], got);
      check("hold_en", lfsr_en[u], 0);
      check("hold_in_ready", in_ready[u], 0);
    end
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    check("post_in_ready", in_ready[u], 1);
    check("post_valid", out_valid[u], 0);
    $display("txn u=%0d in=%02h key=%02h out=%02h lat=%0d hold=%0d", u, b, key, got, n, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int u;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cfg_start[i] = 1'b0; cfg_seed[i] = '0; cfg_taps[i] = '0;
      in_valid[i]  = 1'b0; in_data[i]  = '0; out_ready[i] = 1'b0;
      ref_st[i]    = '0;   ref_taps[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", in_ready[i], 0);
      check("rst_out_valid", out_valid[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_ld", lfsr_ld[i], 0);
      check("rst_en", lfsr_en[i], 0);
      check("rst_out_data", out_data[i], 0);
      check("rst_seed", lfsr_seed[i], 0);
      check("rst_taps", lfsr_taps[i], 0);
    end
    rst = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    tick();
    check("idle_no_accept", in_ready[0], 0);
    check("idle_not_busy", busy[0], 0);
    in_valid[0] = 1'b0;

    // Fixed-key cases with zero taps: key byte is the top byte of the state.
    rekey(0, 32'hFF000000, 32'h0, 0);
    send(0, 8'h5A, 0, got);
    check("fixed_a5", got, 8'hA5);
    send(0, 8'h3C, 0, got);
    check("fixed_3c", got, 8'h3C);
    rekey(0, 32'h0, 32'h0, 0);
    check("zero_seed_sub", lfsr_seed[0], 32'hFFFFFFFF);
    send(0, 8'h00, 0, got);
    check("zero_seed_ff", got, 8'hFF);

    // Full warm-up, then backpressure held for five cycles.
    rekey(1, 32'hACE1_2345, 32'h8020_0003, 0);
    send(1, 8'h96, 5, got);

    // Rekey and byte on the same edge: rekey wins.
    rekey(0, 32'h1234_5678, 32'hB400_0001, 1);
    send(0, 8'h11, 2, got);

    // Reset during GEN cycle 4 aborts the byte.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h77;
    tick();
    in_valid[0] = 1'b0;
    repeat (4) tick();
    check("gen_busy_pre_rst", busy[0], 1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("arst_in_ready", in_ready[i], 0);
      check("arst_out_valid", out_valid[i], 0);
      check("arst_busy", busy[i], 0);
      check("arst_ld", lfsr_ld[i], 0);
      check("arst_en", lfsr_en[i], 0);
      check("arst_out_data", out_data[i], 0);
      check("arst_seed", lfsr_seed[i], 0);
    end
    tick();
    rst = 1'b0;
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_ready0", in_ready[0], 0);
      check("post_rst_ready1", in_ready[1], 0);
      check("post_rst_valid0", out_valid[0], 0);
    end
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;

    // Randomized traffic on both instances.
    rekey(0, $urandom, $urandom, 0);
    rekey(1, $urandom, $urandom, 0);
    for (int t = 0; t < 24; t++) begin
      u = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rekey(u, $urandom, $urandom, bit'($urandom_range(0, 1)));
      send(u, 8'($urandom), int'($urandom_range(0, 3)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
